// File: rtl/alu_ctrl_seq_if.sv
// Bus between the ALU control sequencer and its surroundings (ROM, register file, ALU).
// RetireCnt exists only when INSTR_CNT_EN is defined.
interface alu_ctrl_seq_if #(parameter int PC_W = 8) ();
    logic            Start;
    logic [8:0]      Instr;
    logic            Taken;
    logic [PC_W-1:0] PC;
    logic [2:0]      ALUOp;
    logic [2:0]      RaAddr;
    logic [2:0]      RbAddr;
    logic [2:0]      WrAddr;
    logic            WrEn;
    logic            Busy;
    logic            Done;
    logic            IllegalOp;
`ifdef INSTR_CNT_EN
    logic [15:0]     RetireCnt;
`endif

    modport master (
        input  Start, Instr, Taken,
        output PC, ALUOp, RaAddr, RbAddr, WrAddr, WrEn, Busy, Done, IllegalOp
`ifdef INSTR_CNT_EN
        , output RetireCnt
`endif
    );

    modport slave (
        output Start, Instr, Taken,
        input  PC, ALUOp, RaAddr, RbAddr, WrAddr, WrEn, Busy, Done, IllegalOp
`ifdef INSTR_CNT_EN
        , input RetireCnt
`endif
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer that drives the ALU and register file.
// Optional retired-instruction counter enabled by defining INSTR_CNT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset, waiting for Start
// S_FETCH  | latch ROM word at PC into IR
// S_DECODE | halt / illegal detection
// S_EXEC   | ALU operands presented; branches resolve on Taken
// S_WB     | register-file write of the ALU result, PC advances
// S_HALT   | Done held high until the next Start
module alu_ctrl_seq #(
    parameter int PC_W = 8
) (
    input  logic           Clk,
    input  logic           Reset_n,
    alu_ctrl_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [8:0]      ir, ir_nxt;

    logic [2:0]      opc;
    logic            is_halt;
    logic            is_illegal;
    logic            is_branch;
    logic [PC_W-1:0] br_off;
    logic            start_ok;
    logic            alu_active;

    assign opc        = ir[8:6];
    assign is_halt    = (opc == 3'b000);
    assign is_illegal = (opc == 3'b010) || (opc == 3'b110) || (opc == 3'b111);
    assign is_branch  = (opc == 3'b011) || (opc == 3'b101);
    assign br_off     = {{(PC_W-3){ir[2]}}, ir[2:0]};
    assign start_ok   = bus.Start && ((state == S_IDLE) || (state == S_HALT));
    assign alu_active = (state == S_EXEC) || (state == S_WB);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        case (state)
            S_IDLE, S_HALT: begin
                if (start_ok) begin
                    pc_nxt    = '0;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_nxt    = bus.Instr;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_nxt = S_HALT;
                end else if (is_illegal) begin
                    pc_nxt    = pc + PC_W'(1);
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    // Taken only steers the PC register, never an output directly.
                    pc_nxt    = bus.Taken ? (pc + br_off) : (pc + PC_W'(1));
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                pc_nxt    = pc + PC_W'(1);
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode from state and IR only, so an async reset clears them at once.
    always_comb begin
        bus.PC        = pc;
        bus.ALUOp     = alu_active ? ir[8:6] : 3'b000;
        bus.RaAddr    = alu_active ? ir[5:3] : 3'b000;
        bus.RbAddr    = alu_active ? ir[2:0] : 3'b000;
        bus.WrEn      = (state == S_WB);
        bus.WrAddr    = (state == S_WB) ? ir[5:3] : 3'b000;
        bus.Busy      = (state == S_FETCH) || (state == S_DECODE) || alu_active;
        bus.Done      = (state == S_HALT);
        bus.IllegalOp = (state == S_DECODE) && is_illegal;
    end

`ifdef INSTR_CNT_EN
    logic [15:0] retire_cnt;
    logic        retire;

    assign retire = (state == S_WB) || ((state == S_EXEC) && is_branch);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            retire_cnt <= '0;
        end else if (start_ok) begin
            retire_cnt <= '0;
        end else if (retire && (retire_cnt != 16'hFFFF)) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end

    assign bus.RetireCnt = retire_cnt;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: ROM model, scoreboard of expected
// register writes and illegal-op pulses, plus directed PC/status checks.
module tb_alu_ctrl_seq;

    logic Clk;
    logic Reset_n;
    logic [8:0] rom [256];

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] wr_q  [$];
    logic [7:0]  ill_q [$];

    alu_ctrl_seq_if #(.PC_W(8)) bus ();

    alu_ctrl_seq #(.PC_W(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    assign bus.Instr = rom[bus.PC];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected write beat for an lsf/xor word: {WrAddr, ALUOp, RaAddr, RbAddr}.
    function automatic logic [11:0] wr_beat(input logic [8:0] w);
        return {w[5:3], w[8:6], w[5:3], w[2:0]};
    endfunction

    always @(negedge Clk) begin
        if (Reset_n && bus.WrEn) begin
            if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
            else chk("wr_beat", {bus.WrAddr, bus.ALUOp, bus.RaAddr, bus.RbAddr}, wr_q.pop_front());
        end
        if (Reset_n && bus.IllegalOp) begin
            if (ill_q.size() == 0) chk("ill_unexpected", 1, 0);
            else chk("ill_pc", 32'(bus.PC), 32'(ill_q.pop_front()));
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 9'b0;
    endtask

    task automatic pulse_start();
        @(negedge Clk) bus.Start = 1'b1;
        @(negedge Clk) bus.Start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 200; k++) begin
            if (bus.Done) break;
            @(negedge Clk);
        end
        if (k == 200) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        Reset_n   = 1'b0;
        bus.Start = 1'b0;
        bus.Taken = 1'b0;
        clear_rom();
        #12;
        chk("rst_pc", 32'(bus.PC), 0);
        chk("rst_status", {bus.Busy, bus.Done, bus.WrEn, bus.IllegalOp}, 0);
        chk("rst_alu", {bus.ALUOp, bus.RaAddr, bus.RbAddr, bus.WrAddr}, 0);
        @(negedge Clk) Reset_n = 1'b1;

        // xor r1,r2 then halt: exact cycle positions of EXEC and halt
        rom[0] = 9'b100_001_010;
        wr_q.push_back(wr_beat(rom[0]));
        pulse_start();
        chk("xor_fetch_busy", bus.Busy, 1);
        @(negedge Clk);
        @(negedge Clk);
        chk("xor_exec_alu", {bus.ALUOp, bus.RaAddr, bus.RbAddr}, {3'b100, 3'd1, 3'd2});
        chk("xor_exec_nowr", bus.WrEn, 0);
        @(negedge Clk);
        chk("xor_wb_wren", bus.WrEn, 1);
        @(negedge Clk);
        chk("xor_after_wb_pc", 32'(bus.PC), 1);
        @(negedge Clk);
        @(negedge Clk);
        chk("halt_done", {bus.Done, bus.Busy}, 2'b10);
        chk("halt_pc", 32'(bus.PC), 1);
        chk("halt_alu_idle", {bus.ALUOp, bus.RaAddr, bus.RbAddr}, 0);

        // beq +3, taken then not taken
        clear_rom();
        rom[0] = 9'b101_011_011;
        bus.Taken = 1'b1;
        pulse_start();
        chk("restart_pc0", 32'(bus.PC), 0);
        chk("restart_done_clr", bus.Done, 0);
        @(negedge Clk);
        @(negedge Clk);
        chk("beq_exec_alu", {bus.ALUOp, bus.RaAddr, bus.RbAddr}, {3'b101, 3'd3, 3'd3});
        @(negedge Clk);
        chk("beq_taken_pc", 32'(bus.PC), 3);
        wait_done("beq_t");
        chk("beq_taken_halt_pc", 32'(bus.PC), 3);

        bus.Taken = 1'b0;
        pulse_start();
        wait_done("beq_nt");
        chk("beq_not_taken_pc", 32'(bus.PC), 1);

        // pos branch -4 from PC=1 wraps to 0xFD
        clear_rom();
        rom[0] = 9'b100_010_011;
        rom[1] = 9'b011_000_100;
        wr_q.push_back(wr_beat(rom[0]));
        bus.Taken = 1'b1;
        pulse_start();
        wait_done("wrap");
        chk("wrap_pc", 32'(bus.PC), 32'h0FD);

        // illegal opcode, with a Start issued while busy
        clear_rom();
        rom[0] = 9'b111_000_000;
        ill_q.push_back(8'd0);
        bus.Taken = 1'b0;
        pulse_start();
        @(negedge Clk) bus.Start = 1'b1;
        chk("ill_decode_pulse", bus.IllegalOp, 1);
        @(negedge Clk) bus.Start = 1'b0;
        chk("ill_pulse_one_cycle", bus.IllegalOp, 0);
        chk("ill_pc_after", 32'(bus.PC), 1);
        wait_done("ill");
        chk("ill_halt_pc", 32'(bus.PC), 1);
        chk("ill_q_empty", ill_q.size(), 0);

        // async reset during second write-back
        clear_rom();
        rom[0] = 9'b100_001_010;
        rom[1] = 9'b100_011_100;
        wr_q.push_back(wr_beat(rom[0]));
        wr_q.push_back(wr_beat(rom[1]));
        pulse_start();
        begin
            int k;
            for (k = 0; k < 50; k++) begin
                @(negedge Clk);
                if (bus.WrEn && bus.PC == 8'd1) break;
            end
            if (k == 50) chk("rst_wb_timeout", 0, 1);
        end
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_wb_wren", bus.WrEn, 0);
        chk("rst_wb_pc", 32'(bus.PC), 0);
        chk("rst_wb_busy", {bus.Busy, bus.Done}, 0);
        @(negedge Clk) Reset_n = 1'b1;
        wr_q.push_back(wr_beat(rom[0]));
        wr_q.push_back(wr_beat(rom[1]));
        pulse_start();
        wait_done("rst_rerun");
        chk("rst_rerun_pc", 32'(bus.PC), 2);

`ifdef INSTR_CNT_EN
        clear_rom();
        rom[0] = 9'b100_001_010;
        rom[1] = 9'b100_011_100;
        rom[2] = 9'b100_101_110;
        rom[3] = 9'b101_000_001;
        for (int i = 0; i < 3; i++) wr_q.push_back(wr_beat(rom[i]));
        bus.Taken = 1'b1;
        pulse_start();
        wait_done("cnt");
        chk("cnt_pc", 32'(bus.PC), 4);
        chk("cnt_retired", 32'(bus.RetireCnt), 4);
        pulse_start();
        chk("cnt_cleared", 32'(bus.RetireCnt), 0);
        wait_done("cnt_rerun");
        for (int i = 0; i < 3; i++) wr_q.push_back(wr_beat(rom[i]));
        pulse_start();
        wait_done("cnt_rerun2");
`endif

        repeat (2) @(negedge Clk);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("ill_q_final_empty", ill_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Multi-cycle control sequencer that drives the 8-bit ALU's op-code and register-select inputs, and consumes its Taken flag to resolve branches.
- Holds the program counter and instruction register.
- Steps each 9-bit instruction through FETCH/DECODE/EXEC/WB.
- Sits between the instruction ROM, the register file and the ALU.

Parameters:
- PC_W, 8, program counter width; PC wraps modulo 2^PC_W.

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  begin execution at PC=0; honoured only in IDLE or HALT
- Instr  in  9  instruction word at current PC (combinational ROM read)
- Taken  in  1  ALU branch flag, valid during EXEC
- PC  out  PC_W  current program counter (ROM address)
- ALUOp  out  3  ALU op-code
- RaAddr  out  3  register-file read address A (ALU inA)
- RbAddr  out  3  register-file read address B (ALU inB)
- WrAddr  out  3  register-file write address
- WrEn  out  1  register-file write enable (ALU result)
- Busy  out  1  high in FETCH/DECODE/EXEC/WB
- Done  out  1  sticky high in HALT until Start
- IllegalOp  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Instruction format: IR[8:6] opcode, IR[5:3] ra/rd, IR[2:0] rb or signed branch offset.
- Opcodes:
  - 000 halt
  - 001 lsf (ALUOp 001)
  - 011 pos branch (ALUOp 011)
  - 100 xor (ALUOp 100)
  - 101 beq (ALUOp 101)
  - 010, 110, 111 are illegal.
- Reset (async assert, sync deassert):
  - State IDLE; PC=0, IR=0.
  - ALUOp=000, Ra/Rb/WrAddr=0, WrEn=0, Busy=0, Done=0, IllegalOp=0.
  - Reset mid-instruction aborts with no write; WrEn drops immediately.
- IDLE: outputs at reset values. Start -> FETCH.
- FETCH: IR <= Instr; -> DECODE.
- DECODE:
  - Opcode 000 -> HALT; Done=1 from next cycle; PC unchanged.
  - Illegal opcode -> IllegalOp=1 this cycle; PC <= PC+1; -> FETCH.
  - Otherwise -> EXEC.
- EXEC:
  - ALUOp=IR[8:6], RaAddr=IR[5:3], RbAddr=IR[2:0].
  - lsf/xor -> WB.
  - Branch: Taken sampled at end of EXEC. PC <= Taken ? PC+sext(IR[2:0]) : PC+1; -> FETCH.
- WB:
  - ALUOp/Ra/Rb held from EXEC.
  - WrEn=1, WrAddr=IR[5:3].
  - PC <= PC+1; -> FETCH.
- Outside EXEC/WB: ALUOp=000, Ra/Rb=0. WrEn high only in WB.
- HALT: Busy=0, Done=1. Start -> PC=0, Done=0, -> FETCH.
- Start is ignored while Busy.
- Latency: lsf/xor 4 cycles; branches 3 cycles; halt/illegal 2 cycles.
- PC arithmetic is modulo 2^PC_W; offsets -4..+3. Offset 0 taken = self-loop (legal).
- All state and outputs are registered or decoded from state+IR only; no combinational path from Taken to any output.

Optional Feature:
- Macro INSTR_CNT_EN.
- Defined:
  - Adds output RetireCnt[15:0], counting retired instructions (lsf/xor at WB, branches at EXEC end; not halt/illegal).
  - Cleared by reset and by an accepted Start; saturates at 16'hFFFF.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Reset_n low mid-WB (WrEn=1) -> WrEn=0 same cycle, PC=0, Busy=0; Start afterward restarts at PC=0.
- ROM {0:9'b100_001_010, 1:9'b000_000_000}, Start:
  - Cycle 3 (EXEC): ALUOp=100, RaAddr=1, RbAddr=2.
  - Cycle 4: WrEn=1, WrAddr=1.
  - Then PC=1, HALT, Done=1, Busy=0.
- ROM[0]=9'b101_011_011 (beq +3):
  - Taken=1 -> PC=3 after EXEC, no WrEn.
  - Rerun with Taken=0 -> PC=1.
- PC_W=8, PC=0x01, ROM[1]=9'b011_000_100 (pos, -4), Taken=1 -> PC wraps to 0xFD.
- ROM[0]=9'b111_000_000 -> IllegalOp one-cycle pulse in DECODE, PC=1, no WrEn; Start during Busy ignored.
- INSTR_CNT_EN: program of 3 xor + 1 taken branch + halt -> RetireCnt=4 at Done. Start -> RetireCnt=0.
